// File: rtl/ysyx_24080014_sram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ysyx_24080014_sram
// Brief   : Memory-side valid/ready responder with a word-addressed array,
//           configurable base latency plus LFSR-driven random extra latency,
//           and a response held stable under backpressure.
// Revision: 1.0 - initial release
// ============================================================================
module ysyx_24080014_sram #(
  parameter logic [31:0] ADDR_BASE     = 32'h8000_0000,
  parameter int          DEPTH_WORDS   = 4096,
  parameter int          LAT_MIN       = 1,
  parameter int          LAT_RAND_BITS = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          c_idx_w = $clog2(DEPTH_WORDS);
  localparam int          c_cnt_w = 16;
  // Byte span of the array, one bit wider so the compare cannot wrap.
  localparam logic [32:0] c_span  = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [c_cnt_w-1:0]  cnt_q,   cnt_d;
  logic [15:0]         lfsr_q,  lfsr_d;
  logic                wen_q,   wen_d;
  logic [31:0]         addr_q,  addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wmask_q, wmask_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q,   err_d;

  logic [31:0]         mem [DEPTH_WORDS];

  logic                w_fb;
  logic [15:0]         w_lfsr_step;
  logic [c_cnt_w-1:0]  w_rand;
  logic [31:0]         w_off;
  logic                w_in_range;
  logic [c_idx_w-1:0]  w_idx;
  logic                w_mem_we;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  assign w_fb        = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
  assign w_lfsr_step = {w_fb, lfsr_q[15:1]};

  generate
    if (LAT_RAND_BITS > 0) begin : g_rand
      assign w_rand = c_cnt_w'(lfsr_q[LAT_RAND_BITS-1:0]);
    end else begin : g_no_rand
      assign w_rand = '0;
    end
  endgenerate

  // Address decode on the latched request; offset is taken modulo 2^32.
  assign w_off      = addr_q - ADDR_BASE;
  assign w_in_range = (addr_q >= ADDR_BASE) && ({1'b0, w_off} < c_span);
  assign w_idx      = w_off[c_idx_w+1:2];

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = err_q;

  // Next-state, latency countdown and response capture.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    w_mem_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wen_d   = req_wen;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wmask_d = req_wmask;
          cnt_d   = c_cnt_w'(LAT_MIN - 1) + w_rand;
          lfsr_d  = w_lfsr_step;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_RESP;
          if (w_in_range) begin
            err_d    = 1'b0;
            rdata_d  = wen_q ? 32'h0 : mem[w_idx];
            w_mem_we = wen_q;
          end else begin
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; reset overrides any handshake in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      wen_q   <= wen_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane array write on the access edge; suppressed by reset so a
  // pending write is dropped. Contents are never cleared.
  always_ff @(posedge clk) begin
    if (w_mem_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (wmask_q[i]) begin
          mem[w_idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24080014_sram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_24080014_sram
// Brief   : Self-checking bench for ysyx_24080014_sram. Three instances cover
//           fixed latency, random latency with backpressure, and reset
//           during an outstanding request.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ysyx_24080014_sram;

  logic              clk;
  logic [2:0]        rst;
  logic [2:0]        req_valid, req_ready, req_wen;
  logic [2:0][31:0]  req_addr, req_wdata;
  logic [2:0][3:0]   req_wmask;
  logic [2:0]        rsp_valid, rsp_ready, rsp_err;
  logic [2:0][31:0]  rsp_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: sparse word store keyed by instance and word index,
  // plus a latency generator per instance.
  logic [31:0] mdl [int];
  logic [15:0] m_lfsr    [3];
  int          m_lat_min [3] = '{1, 2, 4};
  logic [15:0] m_rmask   [3] = '{16'h0000, 16'h0003, 16'h0000};

  ysyx_24080014_sram #(.LAT_MIN(1), .LAT_RAND_BITS(0)) u_fix (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_wmask(req_wmask[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  ysyx_24080014_sram #(.LAT_MIN(2), .LAT_RAND_BITS(2)) u_rnd (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_wmask(req_wmask[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  ysyx_24080014_sram #(.LAT_MIN(4), .LAT_RAND_BITS(0)) u_rst (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .req_wmask(req_wmask[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
    .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One full transaction on instance d. Called at posedge+1 with the
  // instance idle; returns at posedge+1 right after the response handshake.
  task automatic do_txn(input int d, input bit wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int stall_max, input bit noisy,
                        output logic [31:0] got_rdata, output logic got_err,
                        output int got_lat);
    logic [31:0] off, word, exp_rdata;
    logic        exp_err;
    int          exp_lat, key, cyc, stall;

    // Model: latency from the reference generator, then the access itself.
    exp_lat   = m_lat_min[d] + int'(m_lfsr[d] & m_rmask[d]);
    m_lfsr[d] = {^(m_lfsr[d] & 16'h002D), m_lfsr[d][15:1]};
    off = addr - 32'h8000_0000;
    if (addr < 32'h8000_0000 || off >= 32'h0000_4000) begin
      exp_err   = 1'b1;
      exp_rdata = 32'h0;
    end else begin
      exp_err = 1'b0;
      key     = d * 4096 + int'(off >> 2);
      word    = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
      if (wen) begin
        for (int i = 0; i < 4; i++)
          if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
        mdl[key]  = word;
        exp_rdata = 32'h0;
      end else begin
        exp_rdata = word;
      end
    end

    got_rdata = 32'hxxxx_xxxx;
    got_err   = 1'bx;
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    chk("rsp_valid_idle", 32'(rsp_valid[d]), 32'd0);
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wmask[d] = wmask;
    req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;

    cyc = 0;
    while (!rsp_valid[d] && cyc < 20) begin
      chk("req_ready_wait", 32'(req_ready[d]), 32'd0);
      if (noisy) begin
        req_valid[d] = 1'($urandom_range(1, 0));
        rsp_ready[d] = 1'($urandom_range(1, 0));
        req_wen[d]   = ~wen;
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;
        req_wmask[d] = 4'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b0;
    got_lat = cyc;
    chk("latency", 32'(got_lat), 32'(exp_lat));
    if (rsp_valid[d]) begin
      stall = $urandom_range(stall_max, 0);
      for (int s = 0; s < stall; s++) begin
        chk("stall_valid", 32'(rsp_valid[d]), 32'd1);
        chk("stall_rdata", rsp_rdata[d], exp_rdata);
        chk("stall_err",   32'(rsp_err[d]), 32'(exp_err));
        chk("stall_ready", 32'(req_ready[d]), 32'd0);
        if (noisy) req_valid[d] = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
      end
      chk("rsp_rdata", rsp_rdata[d], exp_rdata);
      chk("rsp_err",   32'(rsp_err[d]), 32'(exp_err));
      got_rdata = rsp_rdata[d];
      got_err   = rsp_err[d];
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[d] = 1'b0;
      chk("rsp_valid_drop", 32'(rsp_valid[d]), 32'd0);
      chk("req_ready_back", 32'(req_ready[d]), 32'd1);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pick;

  initial begin
    rst = 3'b111;
    req_valid = '0; req_wen = '0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    rsp_ready = '0;
    for (int i = 0; i < 3; i++) m_lfsr[i] = 16'hACE1;

    // Reset with a write request pending on instance 0: must not be taken.
    req_valid[0] = 1'b1; req_wen[0] = 1'b1;
    req_addr[0] = 32'h8000_0010; req_wdata[0] = 32'hBAD0_BAD0; req_wmask[0] = 4'hF;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    end
    rst = 3'b000;
    req_valid[0] = 1'b0;
    chk("rst_req_ready", 32'(req_ready[0]), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata[0], 32'h0);
    chk("rst_rsp_err",   32'(rsp_err[0]), 32'd0);
    @(posedge clk); #1;
    chk("rst_no_accept", 32'(req_ready[0]), 32'd1);

    // Fixed latency, full and partial writes, range errors.
    do_txn(0, 1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, er, lat);
    chk("lit_fix_lat", 32'(lat), 32'd1);
    chk("lit_wr_rdata", rd, 32'h0);
    do_txn(0, 0, 32'h8000_0013, 32'h0, 4'h0, 2, 0, rd, er, lat);
    chk("lit_rd_full", rd, 32'hDEAD_BEEF);
    do_txn(0, 1, 32'h8000_0010, 32'h00AB_0000, 4'b0100, 0, 0, rd, er, lat);
    do_txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("lit_rd_partial", rd, 32'hDEAB_BEEF);
    do_txn(0, 1, 32'h8000_3FFC, 32'h1234_5678, 4'hF, 0, 0, rd, er, lat);
    do_txn(0, 1, 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, rd, er, lat);
    do_txn(0, 0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1, 0, rd, er, lat);
    chk("lit_low_err", 32'(er), 32'd1);
    chk("lit_low_rdata", rd, 32'h0);
    do_txn(0, 1, 32'h8000_4000, 32'h5555_5555, 4'hF, 0, 0, rd, er, lat);
    chk("lit_high_err", 32'(er), 32'd1);
    do_txn(0, 0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, 0, rd, er, lat);
    do_txn(0, 0, 32'h8000_3FFC, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("lit_top_word", rd, 32'h1234_5678);
    chk("lit_top_err", 32'(er), 32'd0);
    do_txn(0, 0, 32'h8000_0000, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("lit_word0", rd, 32'hCAFE_F00D);
    do_txn(0, 1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, rd, er, lat);
    do_txn(0, 0, 32'h8000_0010, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("lit_nomask", rd, 32'hDEAB_BEEF);

    // Random latency with backpressure and ignored inputs outside their state.
    for (int i = 0; i < 8; i++) begin
      do_txn(1, 1, 32'h8000_0100 + 32'(4 * i), 32'hA500_0000 ^ (32'h0101_0101 * 32'(i)),
             4'hF, 5, 1, rd, er, lat);
      if (i == 0) chk("lit_rnd_lat0", 32'(lat), 32'd3);
      if (i == 1) chk("lit_rnd_lat1", 32'(lat), 32'd2);
    end
    for (int i = 0; i < 100; i++) begin
      pick = $urandom_range(8, 0);
      do_txn(1, 0, (pick == 8) ? 32'h7FFF_FFF0 : 32'h8000_0100 + 32'(4 * pick),
             32'h0, 4'h0, 5, 1, rd, er, lat);
    end

    // Reset while a write is outstanding: the write is dropped.
    do_txn(2, 1, 32'h8000_0020, 32'h2222_2222, 4'hF, 0, 0, rd, er, lat);
    chk("lit_lat4", 32'(lat), 32'd4);
    req_wen[2] = 1'b1; req_addr[2] = 32'h8000_0020;
    req_wdata[2] = 32'h1111_1111; req_wmask[2] = 4'hF; req_valid[2] = 1'b1;
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    chk("mid_accepted", 32'(req_ready[2]), 32'd0);
    @(posedge clk); #1;
    rst[2] = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
    end
    rst[2] = 1'b0;
    m_lfsr[2] = 16'hACE1;
    chk("mid_rst_ready", 32'(req_ready[2]), 32'd1);
    repeat (6) begin
      @(posedge clk); #1;
      chk("mid_no_rsp", 32'(rsp_valid[2]), 32'd0);
    end
    do_txn(2, 0, 32'h8000_0020, 32'h0, 4'h0, 0, 0, rd, er, lat);
    chk("lit_dropped_wr", rd, 32'h2222_2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
